// File: rtl/render_pkg.sv
// render_pkg: shared state encoding and default
// angle constants for the render frame sequencer.
package render_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_START,
    S_RENDER,
    S_SWAP
  } state_t;

  localparam int ANGLE_STEP = 16;
  localparam int ANGLE_WRAP = 25736;

  function automatic logic [7:0] satInc8(
    input logic [7:0] v
  );
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/angle_stepper.sv
// angle_stepper: one rotation axis, stepping by +/-STEP
// per accepted frame and folding the result into [0, WRAP).
module angle_stepper #(
  parameter int STEP = 16,
  parameter int WRAP = 25736
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               en,
  input  logic               dir,
  output logic signed [15:0] angle
);

  localparam logic signed [16:0] STEP_V = 17'(STEP);
  localparam logic signed [16:0] WRAP_V = 17'(WRAP);

  logic signed [16:0] cur;
  logic signed [16:0] sum;
  logic signed [16:0] nxt;

  assign cur = {1'b0, angle};

  // Raw step, then a single fold back into range.
  always_comb begin
    sum = dir ? (cur - STEP_V) : (cur + STEP_V);
    nxt = sum;
    unique case (1'b1)
      (sum >= WRAP_V): nxt = sum - WRAP_V;
      (sum < 17'sd0):  nxt = sum + WRAP_V;
      default:         nxt = sum;
    endcase
  end

  // Angle register, updated only on an accepted frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      angle <= '0;
    end else if (load && en) begin
      angle <= nxt[15:0];
    end
  end

endmodule

// File: rtl/render_sequencer.sv
// render_sequencer: per-frame clear/render/swap sequencing
// with auto-rotating view angles and drop accounting.
module render_sequencer #(
  parameter int ANGLE_STEP = render_pkg::ANGLE_STEP,
  parameter int ANGLE_WRAP = render_pkg::ANGLE_WRAP
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               iVSync,
  input  logic               iEnable,
  input  logic [2:0]         iRotEn,
  input  logic [2:0]         iRotDir,
  input  logic               iUseRAM,
  input  logic               i3D,
  output logic               oClearStart,
  input  logic               iClearDone,
  output logic               oRenderStart,
  input  logic               iRenderFinish,
  output logic               oSwap,
  input  logic               iSwapAck,
  output logic signed [15:0] oAlpha,
  output logic signed [15:0] oBeta,
  output logic signed [15:0] oGamma,
  output logic               oUseRAM,
  output logic               o3D,
  output logic               oBusy,
  output logic [15:0]        oFrameCount,
  output logic [7:0]         oDropCount
);

  import render_pkg::*;

  state_t state;
  logic   renderFirst;
  logic   accept;
  logic   drop;

  assign accept = (state == S_IDLE) && iVSync && iEnable;
  assign drop   = (state != S_IDLE) && iVSync;
  assign oBusy  = (state != S_IDLE);

  angle_stepper #(
    .STEP (ANGLE_STEP),
    .WRAP (ANGLE_WRAP)
  ) u_alpha (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .en    (iRotEn[0]),
    .dir   (iRotDir[0]),
    .angle (oAlpha)
  );

  angle_stepper #(
    .STEP (ANGLE_STEP),
    .WRAP (ANGLE_WRAP)
  ) u_beta (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .en    (iRotEn[1]),
    .dir   (iRotDir[1]),
    .angle (oBeta)
  );

  angle_stepper #(
    .STEP (ANGLE_STEP),
    .WRAP (ANGLE_WRAP)
  ) u_gamma (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .en    (iRotEn[2]),
    .dir   (iRotDir[2]),
    .angle (oGamma)
  );

  // Frame FSM; pulses are set on entry into their state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      renderFirst  <= 1'b0;
      oClearStart  <= 1'b0;
      oRenderStart <= 1'b0;
      oSwap        <= 1'b0;
      oUseRAM      <= 1'b0;
      o3D          <= 1'b0;
      oFrameCount  <= '0;
    end else begin
      oClearStart  <= 1'b0;
      oRenderStart <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            state       <= S_CLEAR;
            oClearStart <= 1'b1;
            oUseRAM     <= iUseRAM;
            o3D         <= i3D;
          end
        end
        S_CLEAR: begin
          if (iClearDone) begin
            state        <= S_START;
            oRenderStart <= 1'b1;
          end
        end
        S_START: begin
          state       <= S_RENDER;
          renderFirst <= 1'b1;
        end
        S_RENDER: begin
          renderFirst <= 1'b0;
          if (!renderFirst && iRenderFinish) begin
            state <= S_SWAP;
            oSwap <= 1'b1;
          end
        end
        S_SWAP: begin
          if (iSwapAck) begin
            state       <= S_IDLE;
            oSwap       <= 1'b0;
            oFrameCount <= oFrameCount + 16'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          oSwap <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of ticks that arrive mid-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oDropCount <= '0;
    end else if (drop) begin
      oDropCount <= satInc8(oDropCount);
    end
  end

endmodule
